seg7_scan: RTL and testbench

//   Downstream display stage of the digital clock. Takes the 4-bit digit values

---
 rtl/seg7_scan_if.sv | 24 ++
 rtl/seg7_scan.sv | 136 +++++++++++++
 tb/tb_seg7_scan.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Digit data, blanking controls and multiplexed display drive for seg7_scan.
// The master feeds the digits in; the slave (the scanner) drives the display.
interface seg7_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_tick;

    modport master (
        output digits_in, dp_in, blank_lz, blink_mask,
        input  seg_n, dp_n, an_n, frame_tick
    );

    modport slave (
        input  digits_in, dp_in, blank_lz, blink_mask,
        output seg_n, dp_n, an_n, frame_tick
    );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver: refresh prescaler, per-frame
// digit snapshot, anode dead-time, leading-zero blanking and per-digit blinking.
module seg7_scan #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEAD         = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input logic       clk,
    input logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PreMax  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DeadCnt = PW'(DEAD);
    localparam logic [IW-1:0] IdxMax  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FrmMax  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]           pre_cnt_q, pre_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                  slot_end;
    logic                  frame_start;
    logic [3:0]            cur_digit;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] lz;
    logic                  all_zero;
    logic                  blanked;

    assign slot_end    = (pre_cnt_q == PreMax);
    assign frame_start = slot_end && (idx_q == IdxMax);
    assign cur_digit   = shadow_q[{idx_q, 2'b00} +: 4];

    // Scan position, frame snapshot and blink phase.
    always_comb begin
        pre_cnt_d    = pre_cnt_q + PW'(1);
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        blink_ph_d   = blink_ph_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        frame_tick_d = frame_start;
        if (slot_end) begin
            pre_cnt_d = '0;
            idx_d     = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
        end
        if (frame_start) begin
            shadow_d    = bus.digits_in;
            shadow_dp_d = bus.dp_in;
            if (frame_cnt_q == FrmMax) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    // A digit is a leading zero if it and every more significant digit are zero.
    always_comb begin
        lz       = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (shadow_q[4*k +: 4] == 4'd0);
            lz[k]    = bus.blank_lz & all_zero & (k != 0);
        end
    end

    always_comb begin
        cur_seg = 7'b0111111;
        case (cur_digit)
            4'd0: cur_seg = 7'b1000000;
            4'd1: cur_seg = 7'b1111001;
            4'd2: cur_seg = 7'b0100100;
            4'd3: cur_seg = 7'b0110000;
            4'd4: cur_seg = 7'b0011001;
            4'd5: cur_seg = 7'b0010010;
            4'd6: cur_seg = 7'b0000010;
            4'd7: cur_seg = 7'b1111000;
            4'd8: cur_seg = 7'b0000000;
            4'd9: cur_seg = 7'b0010000;
            default: cur_seg = 7'b0111111;
        endcase
    end

    always_comb begin
        blanked = lz[idx_q] | (blink_ph_q & bus.blink_mask[idx_q]);
        seg_n_d = blanked ? 7'h7F : cur_seg;
        dp_n_d  = blanked | ~shadow_dp_q[idx_q];
        an_n_d  = '1;
        if (!blanked && (pre_cnt_q >= DeadCnt)) begin
            an_n_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q    <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_ph_q   <= blink_ph_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: reset, per-slot decode/blanking vectors via a scoreboard,
// snapshot timing, dead-time duty and blink phase sequences.
module tb_seg7_scan;
    localparam int N  = 4;
    localparam int SD = 8;
    localparam int DT = 2;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (SD),
        .DEAD        (DT),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int pos    = 0;

    typedef struct {
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  lit;
    } vec_t;

    logic [6:0] segtab [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sync to the cycle in which frame_tick is high (scan state idx=0, pre_cnt=0).
    task automatic wait_tick();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.frame_tick) begin
                pos = 0;
                return;
            end
        end
        chk("frame_tick_timeout", 32'd0, 32'd1);
        pos = 0;
    endtask

    task automatic goto(input int n);
        while (pos < n) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic push_slot(input string nm, input int k, input logic [15:0] d,
                             input logic [3:0] dp, input logic lit);
        exp_t e;
        e.name = $sformatf("%s_slot%0d", nm, k);
        if (lit) begin
            e.an  = ~(4'b0001 << k);
            e.seg = segtab[d[4*k +: 4]];
            e.dp  = ~dp[k];
        end else begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({e.name, "_an"}, 32'(bus.an_n), 32'(e.an));
        chk({e.name, "_seg"}, 32'(bus.seg_n), 32'(e.seg));
        chk({e.name, "_dp"}, 32'(bus.dp_n), 32'(e.dp));
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic lz,
                          input logic [3:0] mask);
        bus.digits_in  = d;
        bus.dp_in      = dp;
        bus.blank_lz   = lz;
        bus.blink_mask = mask;
    endtask

    vec_t vecs [6];

    initial begin
        int cnt;
        int lowcnt [4];
        logic [3:0] dark;

        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) segtab[i] = 7'b0111111;

        vecs[0] = '{"v1234", 16'h1234, 4'b0100, 1'b0, 4'b1111};
        vecs[1] = '{"v0050", 16'h0050, 4'b0000, 1'b1, 4'b0011};
        vecs[2] = '{"v0000", 16'h0000, 4'b0000, 1'b1, 4'b0001};
        vecs[3] = '{"v00AF", 16'h00AF, 4'b0000, 1'b0, 4'b1111};
        vecs[4] = '{"v0907", 16'h0907, 4'b1111, 1'b1, 4'b0111};
        vecs[5] = '{"v5678", 16'h5678, 4'b0001, 1'b1, 4'b1111};

        set_in(16'h1234, 4'b0100, 1'b0, 4'b0000);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-slot while a digit is lit.
        wait_tick();
        wait_tick();
        goto(13);
        chk("pre_reset_lit_an", 32'(bus.an_n), 32'h0000000D);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(bus.seg_n), 32'h7F);
        chk("rst_dp", 32'(bus.dp_n), 32'd1);
        chk("rst_an", 32'(bus.an_n), 32'hF);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.an_n != 4'hF) begin
                cnt = i;
                break;
            end
        end
        chk("first_an_low_cycle", 32'(cnt), 32'(DT + 1));
        chk("first_an_value", 32'(bus.an_n), 32'hE);
        chk("first_frame_shadow_zero", 32'(bus.seg_n), 32'(7'b1000000));
        pos = cnt;
        while (!bus.frame_tick && pos < 100) begin
            @(negedge clk);
            pos++;
        end
        chk("first_tick_cycle", 32'(pos), 32'(SD * N));

        // Table vectors: load, wait for the snapshot, then check every slot.
        for (int v = 0; v < 6; v++) begin
            wait_tick();
            set_in(vecs[v].digits, vecs[v].dp, vecs[v].lz, 4'b0000);
            wait_tick();
            for (int k = 0; k < N; k++)
                push_slot(vecs[v].name, k, vecs[v].digits, vecs[v].dp, vecs[v].lit[k]);
            for (int k = 0; k < N; k++) begin
                goto(SD * k + 5);
                pop_check();
            end
        end

        // Dead-time duty, one-hot-or-none anodes and frame_tick period.
        wait_tick();
        set_in(16'h1234, 4'b0100, 1'b0, 4'b0000);
        wait_tick();
        for (int k = 0; k < N; k++) lowcnt[k] = 0;
        cnt = 0;
        for (int i = 1; i <= SD * N; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (!bus.an_n[k]) lowcnt[k]++;
            if ($countones(~bus.an_n) > 1) cnt++;
            if (bus.frame_tick) cnt = cnt + 100;
        end
        for (int k = 0; k < N; k++)
            chk($sformatf("an_low_cycles_d%0d", k), 32'(lowcnt[k]), 32'(SD - DT));
        chk("an_onehot_and_tick_period", 32'(cnt), 32'd100);

        // Mid-frame digit change stays hidden until the next snapshot.
        wait_tick();
        goto(SD + 5);
        set_in(16'h5678, 4'b0000, 1'b0, 4'b0000);
        push_slot("mid_old", 2, 16'h1234, 4'b0100, 1'b1);
        push_slot("mid_old", 3, 16'h1234, 4'b0100, 1'b1);
        push_slot("mid_new", 0, 16'h5678, 4'b0000, 1'b1);
        goto(2 * SD + 5);
        pop_check();
        goto(3 * SD + 5);
        pop_check();
        goto(SD * N + 5);
        pop_check();

        // Blink: digits 3,2 dark in frames 2-3, 6-7 counted from reset release.
        set_in(16'h1234, 4'b0000, 1'b0, 4'b1100);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
        for (int f = 0; f < 8; f++) begin
            dark = ((f / 2) % 2 == 1) ? 4'b1100 : 4'b0000;
            for (int k = 0; k < N; k++) begin
                goto(SD * N * f + SD * k + 5);
                chk($sformatf("blink_f%0d_d%0d", f, k), 32'(bus.an_n[k]), 32'(dark[k]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
